// File: rtl/bit_reverse_reorder_buffer_if.sv
// Stream bundle for the bit-reverse reorder buffer:
// bit-reversed input stream in, natural-order stream out.
interface bit_reverse_reorder_buffer_if #(
    parameter int SIZE  = 32,
    parameter int LOG2N = 3
);
    logic [SIZE-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  out_data;
    logic [LOG2N-1:0] out_index;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_index,
        input  out_valid,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_index,
        output out_valid,
        input  out_ready,
        output out_last
    );
endinterface

// File: rtl/bit_reverse_reorder_buffer.sv
// Ping-pong frame buffer: samples arrive in bit-reversed order,
// one frame fills while the previous frame drains in natural order.
module bit_reverse_reorder_buffer #(
    parameter int N     = 8,
    parameter int SIZE  = 32,
    parameter int LOG2N = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    bit_reverse_reorder_buffer_if.slave bus
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(
        input logic [LOG2N-1:0] v
    );
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = v[LOG2N-1-b];
        end
        return r;
    endfunction

    logic [SIZE-1:0]  bank_q [2][N];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;

    logic             in_acc;
    logic             out_xfer;

    assign bus.in_ready  = ~full_q[wr_bank_q];
    assign bus.out_valid = full_q[rd_bank_q];
    assign bus.out_data  = bank_q[rd_bank_q][rd_cnt_q];
    assign bus.out_index = rd_cnt_q;
    assign bus.out_last  = full_q[rd_bank_q] & (rd_cnt_q == LAST);

    // The two flag updates never target the same bank in one cycle:
    // a filling bank is never full, a draining bank always is.
    always_comb begin
        in_acc    = bus.in_valid & ~full_q[wr_bank_q];
        out_xfer  = full_q[rd_bank_q] & bus.out_ready;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (in_acc) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (out_xfer) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_acc) begin
            bank_q[wr_bank_q][bitrev(wr_cnt_q)] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_bit_reverse_reorder_buffer.sv
// Scoreboard bench for the bit-reverse reorder buffer:
// natural-order expectations are queued as frames are sent.
module tb_bit_reverse_reorder_buffer;
    typedef struct {
        logic [31:0] d;
        logic [2:0]  i;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   out_cnt;
    int   first_cyc;
    int   last_cyc;
    int   stall_cnt;
    bit   rand_rdy;
    bit   hold_v;
    logic [31:0] h_d;
    logic [2:0]  h_i;
    logic        h_l;
    exp_t exp_q[$];

    bit_reverse_reorder_buffer_if #(.SIZE(32), .LOG2N(3)) bus ();

    bit_reverse_reorder_buffer #(
        .N(8), .SIZE(32), .LOG2N(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int brev3(input int v);
        return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
    endfunction

    always @(negedge clk) begin
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: pops on every transfer, checks hold under stall.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && bus.out_valid) begin
                n_cmp++;
                if (bus.out_data !== h_d || bus.out_index !== h_i ||
                    bus.out_last !== h_l) begin
                    n_bad++;
                    $display("FAIL hold: data=%h idx=%0d last=%b need %h %0d %b",
                             bus.out_data, bus.out_index, bus.out_last,
                             h_d, h_i, h_l);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected output: data=%h idx=%0d need none",
                             bus.out_data, bus.out_index);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.d || bus.out_index !== e.i ||
                        bus.out_last !== (e.i == 3'd7)) begin
                        n_bad++;
                        $display("FAIL output: data=%h idx=%0d last=%b need %h %0d %b",
                                 bus.out_data, bus.out_index, bus.out_last,
                                 e.d, e.i, (e.i == 3'd7));
                    end
                end
                out_cnt++;
                if (out_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            hold_v = bus.out_valid && !bus.out_ready;
            h_d    = bus.out_data;
            h_i    = bus.out_index;
            h_l    = bus.out_last;
        end
    end

    // Called at a negedge; returns at the negedge after the accept.
    task automatic send(input logic [31:0] d);
        int w;
        bit ok;
        w  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!ok && w < 200) begin
            #2;
            ok = bus.in_ready;
            if (!ok) stall_cnt++;
            @(negedge clk);
            w++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send timeout: in_ready=%b need 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] nat [8], input bit push);
        exp_t e;
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                e.d = nat[i];
                e.i = 3'(i);
                exp_q.push_back(e);
            end
        end
        for (int k = 0; k < 8; k++) send(nat[brev3(k)]);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain timeout: pending=%0d need 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hdead_beef;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_last !== 1'b0 || bus.out_index !== 3'd0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b vld=%b last=%b idx=%0d need 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.out_index);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post-reset valid: %b need 0", bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [31:0] nat [8];
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            nat[i] = 32'(i);
            e.d = nat[i];
            e.i = 3'(i);
            exp_q.push_back(e);
        end
        for (int k = 0; k < 7; k++) send(nat[brev3(k)]);
        bus.in_valid = 1'b1;
        bus.in_data  = nat[7];
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL early valid: %b need 0", bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency: valid=%b need 1", bus.out_valid);
        end
        wait_drain();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] nat [8];
        out_cnt   = 0;
        stall_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) nat[i] = 32'(100 * f + i);
            send_frame(nat, 1'b1);
        end
        wait_drain();
        n_cmp++;
        if (stall_cnt != 0) begin
            n_bad++;
            $display("FAIL b2b in_ready drops: %0d need 0", stall_cnt);
        end
        n_cmp++;
        if (out_cnt != 24 || last_cyc - first_cyc != 23) begin
            n_bad++;
            $display("FAIL b2b gaps: outs=%0d span=%0d need 24 23",
                     out_cnt, last_cyc - first_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] nat [8];
        exp_t e;
        bus.out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) nat[i] = 32'(1000 + 10 * f + i);
            send_frame(nat, 1'b1);
        end
        for (int i = 0; i < 8; i++) nat[i] = 32'(2000 + i);
        for (int i = 0; i < 8; i++) begin
            e.d = nat[i];
            e.i = 3'(i);
            exp_q.push_back(e);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = nat[0];
        repeat (3) begin
            #2;
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL both full in_ready=%b need 0", bus.in_ready);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 24) begin
            n_bad++;
            $display("FAIL output under stall: pending=%0d need 24",
                     exp_q.size());
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) send(nat[brev3(k)]);
        wait_drain();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] nat [8];
        rand_rdy = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++) nat[i] = $urandom;
            send_frame(nat, 1'b1);
        end
        @(negedge clk);
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] nat [8];
        for (int i = 0; i < 8; i++) nat[i] = 32'(32'h5000 + i);
        for (int k = 0; k < 5; k++) send(nat[brev3(k)]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid reset: vld=%b rdy=%b need 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) nat[i] = 32'(32'h7000 + 3 * i);
        send_frame(nat, 1'b1);
        wait_drain();
        repeat (12) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL extra output after reset: vld=%b need 0",
                     bus.out_valid);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        cyc           = 0;
        out_cnt       = 0;
        first_cyc     = 0;
        last_cyc      = 0;
        stall_cnt     = 0;
        rand_rdy      = 1'b0;
        hold_v        = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
